// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding plus MODE decode and counter sizing helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  // Clock polarity: idle level of sclk.
  function automatic logic mode_cpol(input int mode);
    return mode[1];
  endfunction

  // Clock phase: 0 samples on the leading edge, 1 samples on the trailing edge.
  function automatic logic mode_cpha(input int mode);
    return mode[0];
  endfunction

  // Bit counter must hold the value DATA_WIDTH itself.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with rise/fall detection
// on the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain plus one history flop for edge detection; reset to the
  // input's idle level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples sclk/ss_n/mosi in the clk domain, shifts one
// word in and out per DATA_WIDTH sclk cycles, with a one-deep TX holding register.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | not selected; miso driven 0, output enable off
//  LOAD  | one cycle: fetch holding register (or default) into tx shifter
//  SHIFT | exchanging bits on sclk edges until DATA_WIDTH samples taken
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    MODE             = 3,
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    MSB_FIRST        = 1,
  parameter int                    SLAVE_ACTIVE_LOW = 1,
  parameter int                    SYNC_STAGES      = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX_VALUE = DATA_WIDTH'('hA5A5)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  tx_underrun
);

  localparam logic CPOL    = mode_cpol(MODE);
  localparam logic CPHA    = mode_cpha(MODE);
  localparam int   CW      = cnt_width(DATA_WIDTH);
  localparam logic SS_IDLE = (SLAVE_ACTIVE_LOW != 0);

  spi_state_t state_q, state_d;

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_q;

  logic selected, sel_assert;
  logic lead_edge, trail_edge, sample_edge, drive_edge;

  logic [CW-1:0]         bit_cnt;
  logic                  cnt_full, cnt_last;
  logic [DATA_WIDTH-1:0] rx_sr, rx_next;
  logic [DATA_WIDTH-1:0] tx_sr, tx_shifted, tx_word;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_full;
  logic                  load_take, word_done;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
  endfunction

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SS_IDLE)) u_sync_ss (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ss_n),
    .q    (ss_q),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // mosi only needs its level, so it gets a bare synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_q      = mosi_sync[SYNC_STAGES-1];
  assign selected    = (ss_q != SS_IDLE);
  assign sel_assert  = (SLAVE_ACTIVE_LOW != 0) ? ss_fall : ss_rise;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge : trail_edge;

  assign cnt_full   = (bit_cnt == CW'(DATA_WIDTH));
  assign cnt_last   = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign rx_next    = (MSB_FIRST != 0) ? {rx_sr[DATA_WIDTH-2:0], mosi_q}
                                       : {mosi_q, rx_sr[DATA_WIDTH-1:1]};
  assign tx_shifted = shift_tx(tx_sr);
  assign tx_word    = hold_full ? hold_q : DEFAULT_TX_VALUE;
  assign load_take  = (state_q == LOAD) && selected;

  // CPHA=1 finishes a word on its final sample edge. CPHA=0 still owes the
  // master a trailing edge after the last sample, so the next word is loaded
  // only once that edge has passed; otherwise bit 0 of the new word would be
  // shifted out early.
  assign word_done = CPHA ? (sample_edge && cnt_last) : (drive_edge && cnt_full);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; deselect overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_assert) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (word_done) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (!selected) state_d = IDLE;
  end

  // Holding register: host fills it when empty, LOAD drains it. A host write
  // landing in the LOAD cycle is not forwarded; it waits for the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (load_take && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_q    <= tx_data;
      hold_full <= 1'b1;
    end
  end

  // Shift datapath, bit counter, and the pulsed status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      if (!selected) begin
        if (state_q != IDLE && bit_cnt != '0 && !cnt_full) frame_err <= 1'b1;
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            tx_sr       <= tx_word;
            miso        <= first_bit(tx_word);
            bit_cnt     <= '0;
            tx_underrun <= !hold_full;
          end
          SHIFT: begin
            if (sample_edge && !cnt_full) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + CW'(1);
              if (cnt_last) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end
            end
            if (drive_edge && !cnt_full) begin
              tx_sr <= tx_shifted;
              miso  <= CPHA ? first_bit(tx_sr) : first_bit(tx_shifted);
            end
          end
          default: miso <= 1'b0;
        endcase
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign miso_oe  = busy;
  assign tx_ready = !hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: four instances (modes 0-3; mode 0 is
// LSB-first) driven by a bit-banged master task. Expected rx words are queued
// at stimulus time and popped by a monitor on every rx_valid pulse.
module tb_spi_slave;

  localparam int HALF  = 8;
  localparam int SETUP = 10;
  localparam int NDUT  = 4;

  logic clk;
  logic rst_n;

  logic        sclk_a [NDUT];
  logic        ss_a   [NDUT];
  logic        mosi_a [NDUT];
  logic        miso_a [NDUT];
  logic        oe_a   [NDUT];
  logic [31:0] txd_a  [NDUT];
  logic        txv_a  [NDUT];
  logic        txr_a  [NDUT];
  logic [31:0] rxd_a  [NDUT];
  logic        rxv_a  [NDUT];
  logic        busy_a [NDUT];
  logic        ferr_a [NDUT];
  logic        und_a  [NDUT];

  typedef struct {
    int          idx;
    logic [31:0] w;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   und_cnt  [NDUT];
  int   ferr_cnt [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    spi_slave #(
      .MODE            (g),
      .DATA_WIDTH      (32),
      .MSB_FIRST       ((g == 0) ? 0 : 1),
      .SLAVE_ACTIVE_LOW(1),
      .SYNC_STAGES     (2),
      .DEFAULT_TX_VALUE(32'hA5A5)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk       (sclk_a[g]),
      .ss_n       (ss_a[g]),
      .mosi       (mosi_a[g]),
      .miso       (miso_a[g]),
      .miso_oe    (oe_a[g]),
      .tx_data    (txd_a[g]),
      .tx_valid   (txv_a[g]),
      .tx_ready   (txr_a[g]),
      .rx_data    (rxd_a[g]),
      .rx_valid   (rxv_a[g]),
      .busy       (busy_a[g]),
      .frame_err  (ferr_a[g]),
      .tx_underrun(und_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: pop the scoreboard on each rx_valid, count status pulses.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rxv_a[i]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected rx_valid dut%0d", i), 64'(rxv_a[i]), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx instance", 64'(i), 64'(e.idx));
          check($sformatf("rx_data dut%0d", i), 64'(rxd_a[i]), 64'(e.w));
        end
      end
      if (und_a[i])  und_cnt[i]++;
      if (ferr_a[i]) ferr_cnt[i]++;
    end
  end

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic host_write(input int i, input logic [31:0] w);
    int n;
    n = 0;
    while (!txr_a[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!txr_a[i]) check("tx_ready wait timeout", 64'(txr_a[i]), 64'd1);
    txd_a[i] = w;
    txv_a[i] = 1'b1;
    @(negedge clk);
    txv_a[i] = 1'b0;
    check("tx_ready drop after write", 64'(txr_a[i]), 64'd0);
  endtask

  task automatic select(input int i);
    @(negedge clk);
    ss_a[i] = 1'b0;
    repeat (SETUP) @(negedge clk);
    check($sformatf("busy after select dut%0d", i), 64'(busy_a[i]), 64'd1);
    check($sformatf("miso_oe after select dut%0d", i), 64'(oe_a[i]), 64'd1);
  endtask

  task automatic deselect(input int i);
    @(negedge clk);
    ss_a[i]   = 1'b1;
    mosi_a[i] = 1'b0;
    repeat (12) @(negedge clk);
    check($sformatf("busy after deselect dut%0d", i), 64'(busy_a[i]), 64'd0);
  endtask

  // Bit-banged master for instance i (mode == i, LSB-first only for i == 0).
  task automatic xfer(input int i, input logic [31:0] w, input int nbits, output logic [31:0] rcv);
    logic [1:0] md;
    logic       cpol, cpha, msbf;
    int         k;
    md   = i[1:0];
    cpol = md[1];
    cpha = md[0];
    msbf = (i != 0);
    rcv  = '0;
    for (int b = 0; b < nbits; b++) begin
      k = msbf ? 31 - b : b;
      if (!cpha) begin
        mosi_a[i] = w[k];
        half_wait();
        sclk_a[i] = ~cpol;
        rcv[k]    = miso_a[i];
        half_wait();
        sclk_a[i] = cpol;
      end else begin
        half_wait();
        sclk_a[i] = ~cpol;
        mosi_a[i] = w[k];
        half_wait();
        sclk_a[i] = cpol;
        rcv[k]    = miso_a[i];
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rcv, rcv2;
    logic [1:0]  md;
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      md        = 2'(i);
      sclk_a[i] = md[1];
      ss_a[i]   = 1'b1;
      mosi_a[i] = 1'b0;
      txd_a[i]  = '0;
      txv_a[i]  = 1'b0;
      und_cnt[i]  = 0;
      ferr_cnt[i] = 0;
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("reset tx_ready", 64'(txr_a[3]), 64'd1);
    check("reset busy", 64'(busy_a[3]), 64'd0);
    check("reset miso_oe", 64'(oe_a[3]), 64'd0);
    check("reset miso", 64'(miso_a[3]), 64'd0);
    check("reset rx_data", 64'(rxd_a[3]), 64'd0);

    // Basic exchange on every mode, mode 3 first.
    for (int n = 0; n < NDUT; n++) begin
      int i;
      i = (n == 0) ? 3 : n - 1;
      host_write(i, 32'hDEADBEEF);
      select(i);
      check($sformatf("tx_ready after LOAD dut%0d", i), 64'(txr_a[i]), 64'd1);
      exp_q.push_back('{idx: i, w: 32'h12345678});
      xfer(i, 32'h12345678, 32, rcv);
      deselect(i);
      check($sformatf("master rx dut%0d", i), 64'(rcv), 64'hDEADBEEF);
      check($sformatf("no underrun dut%0d", i), 64'(und_cnt[i]), 64'd0);
    end

    // Empty holding register at select: default word and one underrun pulse.
    select(3);
    exp_q.push_back('{idx: 3, w: 32'hCAFEF00D});
    xfer(3, 32'hCAFEF00D, 32, rcv);
    deselect(3);
    check("underrun default word", 64'(rcv), 64'h0000A5A5);
    check("underrun pulse count", 64'(und_cnt[3]), 64'd1);

    // Back-to-back words with a second host write between them.
    host_write(3, 32'h11112222);
    select(3);
    host_write(3, 32'h33334444);
    exp_q.push_back('{idx: 3, w: 32'hAAAA5555});
    exp_q.push_back('{idx: 3, w: 32'h0F0F0F0F});
    xfer(3, 32'hAAAA5555, 32, rcv);
    xfer(3, 32'h0F0F0F0F, 32, rcv2);
    deselect(3);
    check("b2b first miso word", 64'(rcv), 64'h11112222);
    check("b2b second miso word", 64'(rcv2), 64'h33334444);
    check("b2b underrun count", 64'(und_cnt[3]), 64'd1);
    check("b2b tx_ready", 64'(txr_a[3]), 64'd1);

    // Deselect after 13 bits: frame error, rx_data unchanged.
    select(3);
    xfer(3, 32'h5A5A5A5A, 13, rcv);
    deselect(3);
    check("abort frame_err count", 64'(ferr_cnt[3]), 64'd1);
    check("abort rx_data kept", 64'(rxd_a[3]), 64'h0F0F0F0F);
    check("abort underrun count", 64'(und_cnt[3]), 64'd2);

    // Reset mid-frame at bit 20, then a clean frame.
    select(3);
    xfer(3, 32'h9999AAAA, 20, rcv);
    @(negedge clk);
    rst_n     = 1'b0;
    ss_a[3]   = 1'b1;
    sclk_a[3] = 1'b1;
    mosi_a[3] = 1'b0;
    @(negedge clk);
    check("mid reset miso", 64'(miso_a[3]), 64'd0);
    check("mid reset miso_oe", 64'(oe_a[3]), 64'd0);
    check("mid reset tx_ready", 64'(txr_a[3]), 64'd1);
    check("mid reset rx_data", 64'(rxd_a[3]), 64'd0);
    check("mid reset busy", 64'(busy_a[3]), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    host_write(3, 32'h76543210);
    select(3);
    exp_q.push_back('{idx: 3, w: 32'h89ABCDEF});
    xfer(3, 32'h89ABCDEF, 32, rcv);
    deselect(3);
    check("post reset master rx", 64'(rcv), 64'h76543210);
    check("post reset rx_data", 64'(rxd_a[3]), 64'h89ABCDEF);

    repeat (5) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    check("frame_err dut0", 64'(ferr_cnt[0]), 64'd0);
    check("frame_err dut1", 64'(ferr_cnt[1]), 64'd0);
    check("frame_err dut2", 64'(ferr_cnt[2]), 64'd0);
    check("total underrun dut3", 64'(und_cnt[3]), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
